// File: rtl/colour_heading_tracker.sv
// Colour-blob heading estimator: per-frame column centroid -> heading.
// Optional heading smoothing when HEADING_SMOOTH_EN is defined.
module colour_heading_tracker #(
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 240,
  parameter int CH_BITS      = 4,
  parameter int FOV          = 25,
  parameter int MIN_PIXELS   = 1000,
  parameter int CNT_BITS     = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT+1),
  parameter int HEAD_BITS    = $clog2(FOV+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pix_valid,
  input  logic                 pix_sof,
  input  logic [3*CH_BITS-1:0] pix_data,
  input  logic [1:0]           target_sel,
  input  logic [CH_BITS-1:0]   threshold,
  output logic [HEAD_BITS-1:0] heading,
  output logic                 no_target,
  output logic [CNT_BITS-1:0]  pixel_count,
  output logic                 result_valid,
  output logic                 busy
);

  localparam int COL_BITS =
    (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int ROW_BITS =
    (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int SUM_MAX =
    IMAGE_HEIGHT * ((IMAGE_WIDTH * (IMAGE_WIDTH-1)) / 2);
  localparam int SUM_BITS =
    (SUM_MAX > 1) ? $clog2(SUM_MAX+1) : 1;
  localparam int NUM_BITS =
    (FOV*SUM_MAX > 1) ? $clog2(FOV*SUM_MAX+1) : 2;
  localparam int DEN_BITS  = CNT_BITS + COL_BITS;
  localparam int ITER_BITS = $clog2(NUM_BITS+1);

  localparam logic [COL_BITS-1:0] COL_LAST =
    COL_BITS'(IMAGE_WIDTH-1);
  localparam logic [ROW_BITS-1:0] ROW_LAST =
    ROW_BITS'(IMAGE_HEIGHT-1);
  localparam logic [NUM_BITS-1:0] FOV_N  = NUM_BITS'(FOV);
  localparam logic [DEN_BITS-1:0] WM1_D  = DEN_BITS'(IMAGE_WIDTH-1);
  localparam logic [CNT_BITS-1:0] MIN_C  = CNT_BITS'(MIN_PIXELS);
  localparam logic [HEAD_BITS-1:0] FOV_H = HEAD_BITS'(FOV);

  typedef enum logic {A_IDLE, A_ACCUM} acc_state_t;
  typedef enum logic [1:0] {D_IDLE, D_RUN, D_DONE} div_state_t;

  // ---------------- colour match ----------------
  logic [CH_BITS-1:0] ch_r, ch_g, ch_b;
  logic [CH_BITS-1:0] t_ch, o1_ch, o2_ch;
  logic [CH_BITS:0]   margin;
  logic               is_match;

  assign ch_r = pix_data[3*CH_BITS-1 -: CH_BITS];
  assign ch_g = pix_data[2*CH_BITS-1 -: CH_BITS];
  assign ch_b = pix_data[CH_BITS-1:0];

  // Route the selected channel to T, the other two to O1/O2
  always_comb begin
    t_ch  = ch_r;
    o1_ch = ch_g;
    o2_ch = ch_b;
    unique case (1'b1)
      (target_sel == 2'd1): begin
        t_ch  = ch_g;
        o1_ch = ch_r;
        o2_ch = ch_b;
      end
      (target_sel == 2'd2): begin
        t_ch  = ch_b;
        o1_ch = ch_r;
        o2_ch = ch_g;
      end
      default: begin
        t_ch  = ch_r;
        o1_ch = ch_g;
        o2_ch = ch_b;
      end
    endcase
  end

  assign margin   = {1'b0, t_ch} - {1'b0, threshold};
  assign is_match = (t_ch > threshold)
                 && ({1'b0, o1_ch} < margin)
                 && ({1'b0, o2_ch} < margin);

  // ---------------- position ----------------
  logic [COL_BITS-1:0] col, beat_col;
  logic [ROW_BITS-1:0] row, beat_row;
  logic                col_last, row_last;

  assign beat_col = pix_sof ? '0 : col;
  assign beat_row = pix_sof ? '0 : row;
  assign col_last = (beat_col == COL_LAST);
  assign row_last = (beat_row == ROW_LAST);

  // Column/row of the next beat; sof forces the current beat to (0,0)
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (pix_valid) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : beat_row + 1'b1;
      end else begin
        col <= beat_col + 1'b1;
        row <= beat_row;
      end
    end
  end

  // ---------------- accumulation ----------------
  acc_state_t          acc_state, acc_next;
  logic [SUM_BITS-1:0] sum, sum_next;
  logic [CNT_BITS-1:0] cnt, cnt_next;
  logic                frame_start, in_frame, frame_end;

  assign frame_start = pix_valid & pix_sof;
  assign in_frame    = pix_valid
                     & (pix_sof | (acc_state == A_ACCUM));
  assign frame_end   = in_frame & col_last & row_last;

  assign sum_next = (frame_start ? '0 : sum)
                  + (is_match ? SUM_BITS'(beat_col) : '0);
  assign cnt_next = (frame_start ? '0 : cnt)
                  + CNT_BITS'(is_match);

  // Accumulator state register
  always_ff @(posedge clk) begin
    if (rst) acc_state <= A_IDLE;
    else     acc_state <= acc_next;
  end

  // Enter ACCUM on sof, leave after the last beat
  always_comb begin
    acc_next = acc_state;
    if (frame_end)        acc_next = A_IDLE;
    else if (frame_start) acc_next = A_ACCUM;
  end

  // Running column sum and match count for the current frame
  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= '0;
      cnt <= '0;
    end else if (in_frame) begin
      sum <= sum_next;
      cnt <= cnt_next;
    end
  end

  // Snapshot of the completed frame, handed to the divider
  logic                snap_v;
  logic [SUM_BITS-1:0] snap_sum;
  logic [CNT_BITS-1:0] snap_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_v   <= 1'b0;
      snap_sum <= '0;
      snap_cnt <= '0;
    end else begin
      snap_v <= frame_end;
      if (frame_end) begin
        snap_sum <= sum_next;
        snap_cnt <= cnt_next;
      end
    end
  end

  // ---------------- divider ----------------
  div_state_t           d_state, d_next;
  logic [NUM_BITS-1:0]  num, quo;
  logic [DEN_BITS-1:0]  den, rem, rem_next;
  logic [DEN_BITS:0]    rem_sh;
  logic [ITER_BITS-1:0] iter;
  logic [CNT_BITS-1:0]  res_cnt;
  logic                 q_bit, enough, short_res, div_start;
  logic [HEAD_BITS-1:0] q_head;

  assign enough    = (snap_cnt >= MIN_C);
  assign div_start = snap_v & enough & (d_state == D_IDLE);
  assign short_res = snap_v & ~enough & (d_state == D_IDLE);

  assign rem_sh   = {rem, num[NUM_BITS-1]};
  assign q_bit    = (rem_sh >= {1'b0, den});
  assign rem_next = q_bit ? DEN_BITS'(rem_sh - {1'b0, den})
                          : rem_sh[DEN_BITS-1:0];

  assign q_head = (quo > FOV_N) ? FOV_H : quo[HEAD_BITS-1:0];
  assign busy   = (d_state == D_RUN);

  // Divider state register
  always_ff @(posedge clk) begin
    if (rst) d_state <= D_IDLE;
    else     d_state <= d_next;
  end

  // Snapshots arriving outside D_IDLE are dropped
  always_comb begin
    d_next = d_state;
    case (d_state)
      D_IDLE: if (div_start) d_next = D_RUN;
      D_RUN:  if (iter == ITER_BITS'(1)) d_next = D_DONE;
      D_DONE: d_next = D_IDLE;
      default: d_next = D_IDLE;
    endcase
  end

  // Restoring divide of FOV*sum by cnt*(W-1), MSB first
  always_ff @(posedge clk) begin
    if (rst) begin
      num     <= '0;
      den     <= '0;
      rem     <= '0;
      quo     <= '0;
      iter    <= '0;
      res_cnt <= '0;
    end else if (div_start) begin
      num     <= NUM_BITS'(snap_sum) * FOV_N;
      den     <= DEN_BITS'(snap_cnt) * WM1_D;
      rem     <= '0;
      quo     <= '0;
      iter    <= ITER_BITS'(NUM_BITS);
      res_cnt <= snap_cnt;
    end else if (d_state == D_RUN) begin
      num  <= num << 1;
      rem  <= rem_next;
      quo  <= {quo[NUM_BITS-2:0], q_bit};
      iter <= iter - 1'b1;
    end
  end

  // ---------------- results ----------------
`ifdef HEADING_SMOOTH_EN
  logic               have_prev;
  logic [HEAD_BITS:0] avg_sum;

  assign avg_sum = {1'b0, heading} + {1'b0, q_head};

  // Averaged heading; reloads after reset or a lost target
  always_ff @(posedge clk) begin
    if (rst) begin
      heading      <= '0;
      no_target    <= 1'b1;
      pixel_count  <= '0;
      result_valid <= 1'b0;
      have_prev    <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (short_res) begin
        no_target    <= 1'b1;
        pixel_count  <= snap_cnt;
        result_valid <= 1'b1;
        have_prev    <= 1'b0;
      end else if (d_state == D_DONE) begin
        heading      <= have_prev ? avg_sum[HEAD_BITS:1]
                                  : q_head;
        no_target    <= 1'b0;
        pixel_count  <= res_cnt;
        result_valid <= 1'b1;
        have_prev    <= 1'b1;
      end
    end
  end
`else
  // Publish either the short no-target result or the quotient
  always_ff @(posedge clk) begin
    if (rst) begin
      heading      <= '0;
      no_target    <= 1'b1;
      pixel_count  <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (short_res) begin
        no_target    <= 1'b1;
        pixel_count  <= snap_cnt;
        result_valid <= 1'b1;
      end else if (d_state == D_DONE) begin
        heading      <= q_head;
        no_target    <= 1'b0;
        pixel_count  <= res_cnt;
        result_valid <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_colour_heading_tracker.sv
// Directed bench for colour_heading_tracker in an 8x4 test frame.
// Expected headings follow HEADING_SMOOTH_EN when it is defined.
module tb_colour_heading_tracker;

  logic        clk;
  logic        rst;
  logic        pix_valid;
  logic        pix_sof;
  logic [11:0] pix_data;
  logic [1:0]  target_sel;
  logic [3:0]  threshold;
  logic [4:0]  heading;
  logic        no_target;
  logic [5:0]  pixel_count;
  logic        result_valid;
  logic        busy;

  colour_heading_tracker #(
    .IMAGE_WIDTH (8),
    .IMAGE_HEIGHT(4),
    .CH_BITS     (4),
    .FOV         (25),
    .MIN_PIXELS  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_valid   (pix_valid),
    .pix_sof     (pix_sof),
    .pix_data    (pix_data),
    .target_sel  (target_sel),
    .threshold   (threshold),
    .heading     (heading),
    .no_target   (no_target),
    .pixel_count (pixel_count),
    .result_valid(result_valid),
    .busy        (busy)
  );

`ifdef HEADING_SMOOTH_EN
  localparam int E_GREEN  = 6;
  localparam int E_SMOOTH = 12;
`else
  localparam int E_GREEN  = 0;
  localparam int E_SMOOTH = 0;
`endif

  localparam logic [11:0] RED   = 12'hF00;
  localparam logic [11:0] GREEN = 12'h0F0;

  int          n_tests;
  int          n_fail;
  logic [11:0] fr [32];
  int          pulses;
  logic        busy_seen;
  logic [4:0]  cap_head;
  logic [5:0]  cap_cnt;
  logic        cap_nt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_frame();
    for (int i = 0; i < 32; i++) fr[i] = 12'h000;
  endtask

  task automatic set_col(input int c, input logic [11:0] v);
    for (int r = 0; r < 4; r++) fr[r*8+c] = v;
  endtask

  task automatic beat(input logic [11:0] d, input logic sof);
    pix_valid = 1'b1;
    pix_sof   = sof;
    pix_data  = d;
    @(posedge clk); #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_data  = 12'h000;
  endtask

  task automatic send_frame();
    for (int i = 0; i < 32; i++) beat(fr[i], i == 0);
  endtask

  task automatic observe(input int n);
    pulses    = 0;
    busy_seen = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      if (busy) busy_seen = 1'b1;
      if (result_valid) begin
        pulses++;
        cap_head = heading;
        cap_cnt  = pixel_count;
        cap_nt   = no_target;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_tests++;
    if (heading !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_heading got %0d want 0", heading);
    end
    n_tests++;
    if (no_target !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_no_target got %b want 1", no_target);
    end
    n_tests++;
    if (pixel_count !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_count got %0d want 0", pixel_count);
    end
    n_tests++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_strobe rv=%b busy=%b want 0 0",
               result_valid, busy);
    end
  endtask

  task automatic test_red_right();
    clear_frame();
    set_col(7, RED);
    send_frame();
    observe(40);
    n_tests++;
    if (pulses !== 1) begin
      n_fail++;
      $display("FAIL right_pulses got %0d want 1", pulses);
    end
    n_tests++;
    if (cap_head !== 5'd25 || cap_cnt !== 6'd4 || cap_nt !== 1'b0) begin
      n_fail++;
      $display("FAIL right_result got h=%0d c=%0d nt=%b want 25 4 0",
               cap_head, cap_cnt, cap_nt);
    end
    n_tests++;
    if (busy_seen !== 1'b1) begin
      n_fail++;
      $display("FAIL right_busy got %b want 1", busy_seen);
    end
  endtask

  task automatic test_no_target_hold();
    clear_frame();
    send_frame();
    observe(40);
    n_tests++;
    if (pulses !== 1 || cap_nt !== 1'b1 || cap_cnt !== 6'd0 ||
        cap_head !== 5'd25) begin
      n_fail++;
      $display("FAIL hold got p=%0d nt=%b c=%0d h=%0d want 1 1 0 25",
               pulses, cap_nt, cap_cnt, cap_head);
    end
  endtask

  task automatic test_centre();
    clear_frame();
    set_col(3, RED);
    set_col(4, RED);
    send_frame();
    observe(40);
    n_tests++;
    if (pulses !== 1 || cap_head !== 5'd12 || cap_cnt !== 6'd8 ||
        cap_nt !== 1'b0) begin
      n_fail++;
      $display("FAIL centre got p=%0d h=%0d c=%0d nt=%b want 1 12 8 0",
               pulses, cap_head, cap_cnt, cap_nt);
    end
  endtask

  task automatic test_green();
    clear_frame();
    set_col(0, GREEN);
    target_sel = 2'd1;
    send_frame();
    observe(40);
    n_tests++;
    if (pulses !== 1 || cap_head !== 5'(E_GREEN) || cap_cnt !== 6'd4 ||
        cap_nt !== 1'b0) begin
      n_fail++;
      $display("FAIL green got p=%0d h=%0d c=%0d nt=%b want 1 %0d 4 0",
               pulses, cap_head, cap_cnt, cap_nt, E_GREEN);
    end
    target_sel = 2'd0;
    send_frame();
    observe(40);
    n_tests++;
    if (pulses !== 1 || cap_head !== 5'(E_GREEN) || cap_cnt !== 6'd0 ||
        cap_nt !== 1'b1) begin
      n_fail++;
      $display("FAIL green_as_red got p=%0d h=%0d c=%0d nt=%b want 1 %0d 0 1",
               pulses, cap_head, cap_cnt, cap_nt, E_GREEN);
    end
  endtask

  task automatic test_single();
    clear_frame();
    fr[13] = RED;
    send_frame();
    n_tests++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early rv=%b busy=%b want 0 0",
               result_valid, busy);
    end
    @(posedge clk); #1;
    n_tests++;
    if (result_valid !== 1'b1 || pixel_count !== 6'd1 ||
        no_target !== 1'b1 || heading !== 5'(E_GREEN)) begin
      n_fail++;
      $display("FAIL single_result rv=%b c=%0d nt=%b h=%0d want 1 1 1 %0d",
               result_valid, pixel_count, no_target, heading, E_GREEN);
    end
    observe(30);
    n_tests++;
    if (pulses !== 0 || busy_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL single_after got p=%0d busy=%b want 0 0",
               pulses, busy_seen);
    end
  endtask

  task automatic test_sof_abort();
    for (int i = 0; i < 10; i++) beat(RED, i == 0);
    clear_frame();
    set_col(7, RED);
    send_frame();
    observe(40);
    n_tests++;
    if (pulses !== 1 || cap_head !== 5'd25 || cap_cnt !== 6'd4 ||
        cap_nt !== 1'b0) begin
      n_fail++;
      $display("FAIL sof_abort got p=%0d h=%0d c=%0d nt=%b want 1 25 4 0",
               pulses, cap_head, cap_cnt, cap_nt);
    end
  endtask

  task automatic test_reset_busy();
    logic hit;
    clear_frame();
    set_col(3, RED);
    send_frame();
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(posedge clk); #1;
      if (busy) hit = 1'b1;
    end
    n_tests++;
    if (!hit) begin
      n_fail++;
      $display("FAIL rst_busy_wait busy never rose within 10 cycles");
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++;
    if (heading !== 5'd0 || no_target !== 1'b1 || pixel_count !== 6'd0 ||
        result_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_busy got h=%0d nt=%b c=%0d rv=%b b=%b want 0 1 0 0 0",
               heading, no_target, pixel_count, result_valid, busy);
    end
    observe(30);
    n_tests++;
    if (pulses !== 0 || busy_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_busy_after got p=%0d busy=%b want 0 0",
               pulses, busy_seen);
    end
  endtask

  task automatic test_smooth();
    clear_frame();
    set_col(7, RED);
    send_frame();
    observe(40);
    n_tests++;
    if (pulses !== 1 || cap_head !== 5'd25) begin
      n_fail++;
      $display("FAIL smooth_first got p=%0d h=%0d want 1 25",
               pulses, cap_head);
    end
    clear_frame();
    set_col(0, RED);
    send_frame();
    observe(40);
    n_tests++;
    if (pulses !== 1 || cap_head !== 5'(E_SMOOTH) || cap_cnt !== 6'd4) begin
      n_fail++;
      $display("FAIL smooth_second got p=%0d h=%0d c=%0d want 1 %0d 4",
               pulses, cap_head, cap_cnt, E_SMOOTH);
    end
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    pix_valid  = 1'b0;
    pix_sof    = 1'b0;
    pix_data   = 12'h000;
    target_sel = 2'd0;
    threshold  = 4'd3;
    cap_head   = '0;
    cap_cnt    = '0;
    cap_nt     = 1'b0;
    test_reset();
    test_red_right();
    test_no_target_hold();
    test_centre();
    test_green();
    test_single();
    test_sof_abort();
    test_reset_busy();
    test_smooth();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
